// File: rtl/pc_redirect_ctrl.sv
// PC sequencer with branch redirect, halt/resume and a sticky misaligned-target flag; optional counters under PC_REDIRECT_STATS_EN.
// Latency: pc updates one cycle after an event; flush_if_id/flush_id_ex are combinational in the event cycle.
// Backpressure: stall holds pc in RUN; redirect and halt_req override stall; HALT ignores everything but resume.
module pc_redirect_ctrl #(
    parameter int          PC_W     = 9,
    parameter int unsigned RESET_PC = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            pc_sel,
    input  logic [31:0]     br_pc,
    input  logic            halt_req,
    input  logic            resume,
    output logic [PC_W-1:0] pc,
    output logic            if_valid,
    output logic            flush_if_id,
    output logic            flush_id_ex,
    output logic            halted,
    output logic            misalign_err
`ifdef PC_REDIRECT_STATS_EN
    ,
    output logic [31:0]     redirect_cnt,
    output logic [31:0]     stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_REDIR = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc_nxt;
    logic            misalign_nxt;
    logic            flush_req;
    logic            take_redir;
    logic            stall_hold;
    logic            br_aligned;

    assign br_aligned = (br_pc[1:0] == 2'b00);

    // Target bits above the PC width are dropped on purpose.
    if (PC_W < 32) begin : g_br_hi
        logic unused_br_hi;
        assign unused_br_hi = ^br_pc[31:PC_W];
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        misalign_nxt = misalign_err;
        flush_req    = 1'b0;
        take_redir   = 1'b0;
        stall_hold   = 1'b0;
        case (state)
            ST_RUN: begin
                if (halt_req) begin
                    state_nxt = ST_HALT;
                    flush_req = 1'b1;
                end else if (pc_sel) begin
                    if (br_aligned) begin
                        state_nxt  = ST_REDIR;
                        pc_nxt     = br_pc[PC_W-1:0];
                        flush_req  = 1'b1;
                        take_redir = 1'b1;
                    end else begin
                        // Bad target: do not follow it, park the core instead.
                        misalign_nxt = 1'b1;
                        state_nxt    = ST_HALT;
                    end
                end else if (stall) begin
                    stall_hold = 1'b1;
                end else begin
                    pc_nxt = pc + PC_W'(4);
                end
            end
            ST_REDIR: begin
                state_nxt = ST_RUN;
                pc_nxt    = pc + PC_W'(4);
            end
            ST_HALT: begin
                if (resume) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    assign flush_if_id = flush_req & ~reset;
    assign flush_id_ex = flush_req & ~reset;
    assign if_valid    = (state == ST_RUN);
    assign halted      = (state == ST_HALT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_RUN;
            pc           <= PC_W'(RESET_PC);
            misalign_err <= 1'b0;
        end else begin
            state        <= state_nxt;
            pc           <= pc_nxt;
            misalign_err <= misalign_nxt;
        end
    end

`ifdef PC_REDIRECT_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            redirect_cnt <= '0;
            stall_cnt    <= '0;
        end else begin
            if (take_redir && (redirect_cnt != 32'hFFFF_FFFF)) begin
                redirect_cnt <= redirect_cnt + 32'd1;
            end
            if (stall_hold && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`else
    logic unused_stats;
    assign unused_stats = take_redir ^ stall_hold;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_pc_redirect_ctrl;
    localparam int          PC_W     = 9;
    localparam int unsigned RESET_PC = 0;
    localparam int unsigned PC_MOD   = 1 << PC_W;

    logic            clk = 1'b0;
    logic            reset, stall, pc_sel, halt_req, resume;
    logic [31:0]     br_pc;
    logic [PC_W-1:0] pc;
    logic            if_valid, flush_if_id, flush_id_ex, halted, misalign_err;
`ifdef PC_REDIRECT_STATS_EN
    logic [31:0]     redirect_cnt, stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    pc_redirect_ctrl #(.PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset), .stall(stall), .pc_sel(pc_sel), .br_pc(br_pc),
        .halt_req(halt_req), .resume(resume), .pc(pc), .if_valid(if_valid),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .halted(halted),
        .misalign_err(misalign_err)
`ifdef PC_REDIRECT_STATS_EN
        , .redirect_cnt(redirect_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic clear_in();
        reset = 0; stall = 0; pc_sel = 0; halt_req = 0; resume = 0; br_pc = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_in();
        reset = 1;
        tick();
        reset = 0;
        #1;
        checks++;
        if ({pc, if_valid, halted, misalign_err, flush_if_id, flush_id_ex} !== {PC_W'(RESET_PC), 5'b10000}) begin
            errors++;
            $display("FAIL reset_state got pc=%h v/h/m/f1/f2=%b%b%b%b%b want pc=%h 10000", pc, if_valid,
                     halted, misalign_err, flush_if_id, flush_id_ex, PC_W'(RESET_PC));
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (pc !== PC_W'(4 * i) || if_valid !== 1'b1) begin
                errors++;
                $display("FAIL free_run_%0d got pc=%h if_valid=%b want pc=%h if_valid=1", i, pc, if_valid, PC_W'(4 * i));
            end
        end
    endtask

    task automatic test_redirect_stall();
        pc_sel = 1; br_pc = 32'h40; stall = 1;
        #1;
        checks++;
        if (flush_if_id !== 1'b1 || flush_id_ex !== 1'b1) begin
            errors++;
            $display("FAIL redir_flush got %b%b want 11", flush_if_id, flush_id_ex);
        end
        tick();
        clear_in();
        checks++;
        if (pc !== 9'h040 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_target got pc=%h if_valid=%b want pc=040 if_valid=0", pc, if_valid);
        end
        tick();
        checks++;
        if (pc !== 9'h044 || if_valid !== 1'b1) begin
            errors++;
            $display("FAIL redir_resume got pc=%h if_valid=%b want pc=044 if_valid=1", pc, if_valid);
        end
    endtask

    task automatic test_wrap();
        pc_sel = 1; br_pc = 32'hFFFF_F1F8;
        tick();
        clear_in();
        checks++;
        if (pc !== 9'h1F8) begin
            errors++;
            $display("FAIL br_truncate got pc=%h want 1f8", pc);
        end
        tick();
        checks++;
        if (pc !== 9'h1FC) begin
            errors++;
            $display("FAIL pre_wrap got pc=%h want 1fc", pc);
        end
        tick();
        checks++;
        if (pc !== 9'h000 || if_valid !== 1'b1) begin
            errors++;
            $display("FAIL pc_wrap got pc=%h if_valid=%b want pc=000 if_valid=1", pc, if_valid);
        end
    endtask

    task automatic test_halt_priority();
        logic [PC_W-1:0] p;
        p = pc;
        halt_req = 1; pc_sel = 1; br_pc = 32'h80; stall = 1;
        #1;
        checks++;
        if (flush_if_id !== 1'b1 || flush_id_ex !== 1'b1) begin
            errors++;
            $display("FAIL halt_flush got %b%b want 11", flush_if_id, flush_id_ex);
        end
        tick();
        clear_in();
        checks++;
        if (halted !== 1'b1 || pc !== p || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL halt_enter got halted=%b pc=%h if_valid=%b want 1 %h 0", halted, pc, if_valid, p);
        end
        pc_sel = 1; br_pc = 32'h100; halt_req = 1; stall = 1;
        #1;
        checks++;
        if (flush_if_id !== 1'b0 || flush_id_ex !== 1'b0) begin
            errors++;
            $display("FAIL halt_ignore_flush got %b%b want 00", flush_if_id, flush_id_ex);
        end
        tick();
        clear_in();
        checks++;
        if (halted !== 1'b1 || pc !== p) begin
            errors++;
            $display("FAIL halt_ignore got halted=%b pc=%h want 1 %h", halted, pc, p);
        end
        resume = 1;
        tick();
        clear_in();
        checks++;
        if (halted !== 1'b0 || if_valid !== 1'b1 || pc !== p) begin
            errors++;
            $display("FAIL resume_run got halted=%b if_valid=%b pc=%h want 0 1 %h", halted, if_valid, pc, p);
        end
        tick();
        checks++;
        if (pc !== p + PC_W'(4)) begin
            errors++;
            $display("FAIL resume_advance got pc=%h want %h", pc, p + PC_W'(4));
        end
    endtask

    task automatic test_misalign();
        logic [PC_W-1:0] p;
        p = pc;
        pc_sel = 1; br_pc = 32'h42;
        tick();
        clear_in();
        checks++;
        if (misalign_err !== 1'b1 || halted !== 1'b1 || pc !== p) begin
            errors++;
            $display("FAIL misalign got err=%b halted=%b pc=%h want 1 1 %h", misalign_err, halted, pc, p);
        end
        reset = 1;
        tick();
        clear_in();
        checks++;
        if (misalign_err !== 1'b0 || halted !== 1'b0 || pc !== PC_W'(RESET_PC)) begin
            errors++;
            $display("FAIL misalign_reset got err=%b halted=%b pc=%h want 0 0 %h", misalign_err, halted, pc,
                     PC_W'(RESET_PC));
        end
    endtask

`ifdef PC_REDIRECT_STATS_EN
    task automatic test_stats();
        clear_in();
        reset = 1;
        tick();
        clear_in();
        pc_sel = 1; br_pc = 32'h20;
        tick();
        clear_in();
        tick();
        stall = 1;
        for (int i = 0; i < 5; i++) tick();
        clear_in();
        pc_sel = 1; br_pc = 32'h60;
        tick();
        clear_in();
        stall = 1;   // stall during the squashed slot is not a held RUN cycle
        tick();
        clear_in();
        tick();
        checks++;
        if (redirect_cnt !== 32'd2 || stall_cnt !== 32'd5) begin
            errors++;
            $display("FAIL stats got redirect_cnt=%0d stall_cnt=%0d want 2 5", redirect_cnt, stall_cnt);
        end
    endtask
`endif

    task automatic test_random();
        int unsigned m_pc, m_rc, m_sc;
        bit m_halt, m_dead, m_mis, exp_flush;
        logic [PC_W+4:0] act_v, exp_v;
        clear_in();
        reset = 1;
        tick();
        m_pc = RESET_PC % PC_MOD; m_halt = 0; m_dead = 0; m_mis = 0; m_rc = 0; m_sc = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            reset    = ($urandom_range(99) == 0);
            pc_sel   = ($urandom_range(99) < 15);
            halt_req = ($urandom_range(99) < 3);
            resume   = ($urandom_range(99) < 25);
            stall    = ($urandom_range(99) < 30);
            br_pc    = $urandom;
            if ($urandom_range(4) != 0) br_pc[1:0] = 2'b00;
            #1;
            exp_flush = !reset && !m_halt && !m_dead && (halt_req || (pc_sel && br_pc % 4 == 0));
            exp_v = {PC_W'(m_pc), !m_halt && !m_dead, m_halt, m_mis, exp_flush, exp_flush};
            act_v = {pc, if_valid, halted, misalign_err, flush_if_id, flush_id_ex};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL random_c%0d got pc/v/h/m/f1/f2=%b want %b", cyc, act_v, exp_v);
            end
`ifdef PC_REDIRECT_STATS_EN
            checks++;
            if (redirect_cnt !== m_rc || stall_cnt !== m_sc) begin
                errors++;
                $display("FAIL random_stats_c%0d got %0d/%0d want %0d/%0d", cyc, redirect_cnt, stall_cnt, m_rc, m_sc);
            end
`endif
            if (reset) begin
                m_pc = RESET_PC % PC_MOD; m_halt = 0; m_dead = 0; m_mis = 0; m_rc = 0; m_sc = 0;
            end else if (m_halt) begin
                if (resume) m_halt = 0;
            end else if (m_dead) begin
                m_dead = 0;
                m_pc = (m_pc + 4) % PC_MOD;
            end else if (halt_req) begin
                m_halt = 1;
            end else if (pc_sel) begin
                if (br_pc % 4 == 0) begin
                    m_pc = br_pc % PC_MOD;
                    m_dead = 1;
                    if (m_rc != 32'hFFFF_FFFF) m_rc++;
                end else begin
                    m_mis = 1;
                    m_halt = 1;
                end
            end else if (stall) begin
                if (m_sc != 32'hFFFF_FFFF) m_sc++;
            end else begin
                m_pc = (m_pc + 4) % PC_MOD;
            end
            tick();
        end
        clear_in();
    endtask

    initial begin
        clear_in();
        tick();
        test_reset();
        test_redirect_stall();
        test_wrap();
        test_halt_priority();
        test_misalign();
`ifdef PC_REDIRECT_STATS_EN
        test_stats();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
